// File: rtl/piso_frame_tx_if.sv
// Handshake and serial-line bundle for the framed PISO transmitter.
interface piso_frame_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] pIn;
    logic              load;
    logic              ready;
    logic              sOut;
    logic              busy;
    logic              done;

    modport master (output pIn, load, input ready, sOut, busy, done);
    modport slave  (input pIn, load, output ready, sOut, busy, done);
endinterface

// File: rtl/piso_frame_tx.sv
// Framed parallel-in serial-out transmitter: start, data LSB-first, optional
// even parity, stop; each bit held BIT_CYCLES clocks.
module piso_frame_tx #(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 1,
    parameter int PARITY_EN  = 1
) (
    input logic            clk,
    input logic            rst,
    piso_frame_tx_if.slave bus
);
    localparam int BW = $clog2(DATA_W + 1);
    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state, stateNext;
    logic [DATA_W-1:0] shreg, shregNext;
    logic              parBit, parBitNext;
    logic [BW-1:0]     bitCnt, bitCntNext;
    logic [CW-1:0]     cycCnt, cycCntNext;
    logic              bitEnd;
    logic              sOutNext, readyNext, doneNext;

    always_comb begin
        stateNext  = state;
        shregNext  = shreg;
        parBitNext = parBit;
        bitCntNext = bitCnt;
        cycCntNext = cycCnt;
        bitEnd     = (cycCnt == CW'(BIT_CYCLES - 1));

        if (state != IDLE) begin
            cycCntNext = bitEnd ? '0 : cycCnt + 1'b1;
        end

        case (state)
            IDLE: begin
                if (bus.load) begin
                    stateNext  = START;
                    shregNext  = bus.pIn;
                    parBitNext = ^bus.pIn;
                    bitCntNext = '0;
                    cycCntNext = '0;
                end
            end
            START: begin
                if (bitEnd) stateNext = DATA;
            end
            DATA: begin
                if (bitEnd) begin
                    shregNext  = shreg >> 1;
                    bitCntNext = bitCnt + 1'b1;
                    if (bitCnt == BW'(DATA_W - 1)) begin
                        stateNext = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bitEnd) stateNext = STOP;
            end
            STOP: begin
                if (bitEnd) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase

        // Outputs are decoded from the next state so they can be registered
        // without adding a cycle of latency after accept.
        case (stateNext)
            START:   sOutNext = 1'b0;
            DATA:    sOutNext = shregNext[0];
            PARITY:  sOutNext = parBitNext;
            default: sOutNext = 1'b1;
        endcase
        readyNext = (stateNext == IDLE);
        doneNext  = (stateNext == STOP) && (cycCntNext == CW'(BIT_CYCLES - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            parBit    <= 1'b0;
            bitCnt    <= '0;
            cycCnt    <= '0;
            bus.sOut  <= 1'b1;
            bus.ready <= 1'b1;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
        end else begin
            state     <= stateNext;
            shreg     <= shregNext;
            parBit    <= parBitNext;
            bitCnt    <= bitCntNext;
            cycCnt    <= cycCntNext;
            bus.sOut  <= sOutNext;
            bus.ready <= readyNext;
            bus.busy  <= !readyNext;
            bus.done  <= doneNext;
        end
    end
endmodule

// File: tb/tb_piso_frame_tx.sv
// Scoreboard bench: three transmitter configurations, expected serial frames
// queued per clock and checked by independent monitors.
module tb_piso_frame_tx;
    logic clk = 1'b0;
    logic rst;
    logic monEn = 1'b0;

    always #5 clk = ~clk;

    piso_frame_tx_if #(.DATA_W(8)) b0 ();
    piso_frame_tx_if #(.DATA_W(8)) b1 ();
    piso_frame_tx_if #(.DATA_W(8)) b2 ();

    piso_frame_tx #(.DATA_W(8), .BIT_CYCLES(1), .PARITY_EN(1)) u0 (.clk(clk), .rst(rst), .bus(b0));
    piso_frame_tx #(.DATA_W(8), .BIT_CYCLES(1), .PARITY_EN(0)) u1 (.clk(clk), .rst(rst), .bus(b1));
    piso_frame_tx #(.DATA_W(8), .BIT_CYCLES(4), .PARITY_EN(1)) u2 (.clk(clk), .rst(rst), .bus(b2));

    typedef struct packed {
        logic s;
        logic d;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int nPass  = 0;
    int nTotal = 0;

    function automatic void check(string name, logic act, logic exp);
        nTotal++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    endfunction

    // Pattern characters are serial bits in time order; each is held for the
    // configuration's bit period and done is expected on the final clock.
    function automatic void pushPattern(int d, string p);
        int   bc;
        exp_t e;
        bc = (d == 2) ? 4 : 1;
        for (int i = 0; i < p.len(); i++) begin
            for (int r = 0; r < bc; r++) begin
                e.s = (p[i] == "1");
                e.d = (i == p.len() - 1) && (r == bc - 1);
                case (d)
                    0:       q0.push_back(e);
                    1:       q1.push_back(e);
                    default: q2.push_back(e);
                endcase
            end
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (monEn) begin
            check("d0 busy", b0.busy, logic'(q0.size() != 0));
            if (b0.busy && q0.size() != 0) begin
                e = q0.pop_front();
                check("d0 ready", b0.ready, 1'b0);
                check("d0 sOut", b0.sOut, e.s);
                check("d0 done", b0.done, e.d);
            end else if (!b0.busy) begin
                check("d0 idle sOut", b0.sOut, 1'b1);
                check("d0 idle ready", b0.ready, 1'b1);
                check("d0 idle done", b0.done, 1'b0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (monEn) begin
            check("d1 busy", b1.busy, logic'(q1.size() != 0));
            if (b1.busy && q1.size() != 0) begin
                e = q1.pop_front();
                check("d1 ready", b1.ready, 1'b0);
                check("d1 sOut", b1.sOut, e.s);
                check("d1 done", b1.done, e.d);
            end else if (!b1.busy) begin
                check("d1 idle sOut", b1.sOut, 1'b1);
                check("d1 idle ready", b1.ready, 1'b1);
                check("d1 idle done", b1.done, 1'b0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (monEn) begin
            check("d2 busy", b2.busy, logic'(q2.size() != 0));
            if (b2.busy && q2.size() != 0) begin
                e = q2.pop_front();
                check("d2 ready", b2.ready, 1'b0);
                check("d2 sOut", b2.sOut, e.s);
                check("d2 done", b2.done, e.d);
            end else if (!b2.busy) begin
                check("d2 idle sOut", b2.sOut, 1'b1);
                check("d2 idle ready", b2.ready, 1'b1);
                check("d2 idle done", b2.done, 1'b0);
            end
        end
    end

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one word for a single accept edge, then queues its frame.
    task automatic send(int d, logic [7:0] w, string p);
        case (d)
            0: begin b0.pIn = w; b0.load = 1'b1; end
            1: begin b1.pIn = w; b1.load = 1'b1; end
            default: begin b2.pIn = w; b2.load = 1'b1; end
        endcase
        @(posedge clk);
        #1;
        pushPattern(d, p);
        b0.load = 1'b0;
        b1.load = 1'b0;
        b2.load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        b0.pIn  = 8'hFF; b0.load = 1'b1;
        b1.pIn  = 8'h07; b1.load = 1'b1;
        b2.pIn  = 8'hFF; b2.load = 1'b1;

        // Reset held 3 clocks with load asserted: nothing may start.
        @(posedge clk);
        #1 monEn = 1'b1;
        idle(2);
        rst     = 1'b0;
        b0.load = 1'b0;
        b2.load = 1'b0;
        // d1 keeps load high across reset release and accepts on the next edge.
        @(posedge clk);
        #1;
        pushPattern(1, "0111000001");
        b1.load = 1'b0;
        idle(11);

        send(0, 8'hA5, "01010010101");
        idle(12);
        send(0, 8'h07, "01110000011");
        idle(12);
        send(1, 8'hA5, "0101001011");
        idle(11);
        send(2, 8'h01, "01000000011");
        idle(45);

        // Back-to-back: load stays high, second word accepted after one IDLE clock.
        b0.pIn  = 8'h3C;
        b0.load = 1'b1;
        @(posedge clk);
        #1;
        pushPattern(0, "00011110001");
        b0.pIn = 8'hC3;
        idle(12);
        pushPattern(0, "01100001101");
        b0.load = 1'b0;
        idle(12);

        // Reset during data bit 3 of 8'h55 aborts the frame.
        send(0, 8'h55, "01010101001");
        idle(4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        q0.delete();
        rst = 1'b0;
        idle(3);
        send(0, 8'h55, "01010101001");
        idle(14);

        check("d0 frames drained", logic'(q0.size() == 0), 1'b1);
        check("d1 frames drained", logic'(q1.size() == 0), 1'b1);
        check("d2 frames drained", logic'(q2.size() == 0), 1'b1);

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end
endmodule

// File: doc/piso_frame_tx.md
Name: piso_frame_tx

Overview:
Parallel-in, serial-out framed transmitter that drives a single-bit serial line.
- Accepts a DATA_W-bit word through a valid/ready handshake.
- Emits start bit, data LSB-first, optional even-parity bit, then stop bit.
- Each bit is held for BIT_CYCLES clocks.
- Acts as the sending end for the team's serial shift-register datapaths; its output feeds a serial-in chain directly.

Parameters:
DATA_W, 8, data bits per frame (1..32).
BIT_CYCLES, 1, clocks each serial bit is held (>=1).
PARITY_EN, 1, 1 = insert even-parity bit after data; 0 = omit.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
pIn  input  DATA_W  parallel word; sampled only on accept.
load  input  1  word valid.
ready  output  1  transmitter can accept a word.
sOut  output  1  serial line; idle level 1.
busy  output  1  frame in progress (any state except IDLE).
done  output  1  one-cycle pulse on the last clock of the stop bit.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; sOut=1, ready=1, busy=0, done=0.
  - Shift register, bit counter and cycle counter cleared.
  - Reset mid-frame aborts the frame: sOut=1 from the next edge, no done pulse, partial word discarded.
- Accept: `load && ready` at an edge.
  - pIn is latched into the shift register and parity is computed as the XOR of pIn.
  - state goes to START and ready drops at that edge.
  - load while ready=0 is ignored. pIn changes after accept do not affect the frame.
- FSM states: IDLE -> START -> DATA -> PARITY (only if PARITY_EN) -> STOP -> IDLE.
  - IDLE: sOut=1, ready=1.
  - START: sOut=0 for BIT_CYCLES clocks.
  - DATA: sOut = shreg[0]. Shift right every BIT_CYCLES clocks. Exactly DATA_W bits sent, LSB first.
  - PARITY: sOut = even parity, i.e. total ones in data+parity is even. Held BIT_CYCLES clocks.
  - STOP: sOut=1 for BIT_CYCLES clocks. done=1 on the final clock of STOP. Next edge returns to IDLE.
- Timing:
  - ready=0 from the accept edge until the STOP->IDLE edge.
  - Minimum gap between frames is 1 clock of IDLE.
  - Frame length = (DATA_W + PARITY_EN + 2) * BIT_CYCLES clocks.
- Latency: sOut=0 (start bit) is visible in the first cycle after the accept edge.
- Counters:
  - Cycle counter wraps from BIT_CYCLES-1 to 0 on each bit boundary.
  - Bit counter width = clog2(DATA_W+1).
  - Neither counter advances in IDLE.
- busy = !ready except during reset. All outputs are registered; no combinational path from load or pIn to sOut.
- Simultaneous rst and load: rst wins; no word accepted.

Test Plan:
- Reset: hold rst=1 for 3 clk with load=1, pIn=8'hFF -> sOut=1, ready=1, busy=0, done=0 throughout. No frame starts after rst drops unless load is still high, which then accepts on the next edge.
- Basic frame (defaults), accept pIn=8'hA5 -> sOut over the 11 clocks after accept = 0,1,0,1,0,0,1,0,1,0,1.
  - Order: start, data LSB-first, parity=0, stop.
  - done pulses on clock 11; ready returns 1 on clock 12.
- Parity: pIn=8'h07 (three ones) -> parity bit = 1. With PARITY_EN=0, the same word gives a 10-clock frame, no parity bit, and done on clock 10.
- BIT_CYCLES=4, pIn=8'h01 -> start low for 4 clocks, then data bit0=1 for 4 clocks, then seven 0 bits of 4 clocks each. Total frame 44 clocks.
- Back-to-back: keep load=1 with words 8'h3C then 8'hC3 -> second accept occurs exactly 1 IDLE clock after the first STOP ends. load asserted mid-frame is ignored.
- Reset mid-frame: assert rst during DATA bit 3 of 8'h55 -> sOut=1 the next cycle, no done pulse, ready=1 after rst deasserts. A subsequent 8'h55 frame is transmitted correctly.
